// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM encoding and
// the add/sub select values.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_slice.sv
// One-bit full-adder slice used by the serial datapath, built from two half
// adders with the two partial carries ORed together.
module serial_halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    serial_halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    serial_halfadder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, with
// valid/ready handshakes on both the operand and result sides.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    serial_fa_slice u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (s_bit),
        .cout (c_next)
    );

    assign last_bit = (cnt_q == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)             state_d = RUN;
            RUN:     if (last_bit)             state_d = DONE;
            DONE:    if (out_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B at load time and seed the carry.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = (sub == OP_SUB) ? ~b : b;
                    carry_d = (sub == OP_SUB);
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                carry_d = c_next;
                if (last_bit) begin
                    cout_d = c_next;
                    ovf_d  = carry_q ^ c_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = res_q;
        cout      = cout_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: vector table plus handwritten corner sequences,
// with expected results queued at acceptance and checked on out_valid.
module tb_serial_addsub;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;
    vec_t sb[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        vec_t v;
        logic [W:0] full;
        v.a = x;
        v.b = y;
        v.sub = s;
        if (!s) full = {1'b0, x} + {1'b0, y};
        else    full = {1'b0, x} + {1'b0, ~y} + 1'b1;
        v.res = full[W-1:0];
        v.co  = full[W];
        if (!s) v.ov = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        else    v.ov = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        return v;
    endfunction

    task automatic apply(input vec_t v, input int bp_cycles, input bit hold_iv);
        vec_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1;
        out_ready = (bp_cycles == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        sb.push_back(v);
        #1;
        if (hold_iv) begin
            a = '1; b = '1;
        end else begin
            in_valid = 1'b0;
        end
        chk("in_ready_run", in_ready, 0);
        got = 0;
        lat = 0;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("out_valid_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        chk("latency", lat, W);
        e = sb.pop_front();
        $display("op %02h %s %02h -> result %02h cout %0d ovf %0d (exp %02h %0d %0d)",
                 e.a, e.sub ? "-" : "+", e.b, result, cout, overflow, e.res, e.co, e.ov);
        chk("result", result, e.res);
        chk("cout", cout, e.co);
        chk("overflow", overflow, e.ov);
        for (int i = 0; i < bp_cycles; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, e.res);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("result_hold", result, e.res);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        tbl[0] = '{a: 8'h05, b: 8'h03, sub: 1'b0, res: 8'h08, co: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, co: 1'b0, ov: 1'b1};
        tbl[3] = '{a: 8'h03, b: 8'h05, sub: 1'b1, res: 8'hFE, co: 1'b0, ov: 1'b0};
        tbl[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, co: 1'b1, ov: 1'b1};
        tbl[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, res: 8'h00, co: 1'b1, ov: 1'b0};
        tbl[6] = '{a: 8'h80, b: 8'h80, sub: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) apply(tbl[i], 0, 0);

        for (int i = 0; i < 8; i++) begin
            v = mk(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            apply(v, 0, 0);
        end

        // Backpressure: hold DONE for 5 cycles.
        apply('{a: 8'h10, b: 8'h20, sub: 1'b0, res: 8'h30, co: 1'b0, ov: 1'b0}, 5, 0);

        // Operands change while RUN with in_valid held high.
        apply('{a: 8'h11, b: 8'h22, sub: 1'b0, res: 8'h33, co: 1'b0, ov: 1'b0}, 0, 1);
        @(negedge clk);
        chk("no_extra_accept", in_ready, 1);

        // Reset after 3 RUN edges discards the operation.
        @(negedge clk);
        a = 8'h55; b = 8'h0F; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(mk(8'h55, 8'h0F, 1'b0));
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        $display("reset mid-RUN: in_ready %0d out_valid %0d result %02h", in_ready, out_valid, result);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply('{a: 8'h01, b: 8'h01, sub: 1'b0, res: 8'h02, co: 1'b0, ov: 1'b0}, 0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor with valid/ready handshakes on input and output.
- Accepts two operands and an add/sub select, then processes one bit per clock, LSB first, through a full-adder slice with a registered carry.
- Sits between the operand source and the result consumer of the Adder Subtractor datapath.
- Trades latency (WIDTH cycles) for a single-bit datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and sub are valid
- in_ready  output  1  block can accept a new operation
- a  input  WIDTH  operand A (two's complement or unsigned)
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result, cout and overflow are valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, mod 2^WIDTH
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking and reset:
  - Single clock domain (clk).
  - Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - State = IDLE; in_ready=1; out_valid=0; result=0; cout=0; overflow=0.
  - Internal shift registers, carry and bit counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, go to RUN and load:
    - a_sh = a.
    - b_sh = sub ? ~b : b.
    - carry = sub.
    - cnt = 0.
    - result shift register = 0.
  - Without in_valid, stay in IDLE.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge:
    - s = a_sh[0] ^ b_sh[0] ^ carry.
    - c_next = majority(a_sh[0], b_sh[0], carry).
    - Shift a_sh and b_sh right by 1.
    - Shift s into the result MSB (result register shifts right).
    - carry = c_next; cnt++.
  - When cnt == WIDTH-1 on an edge (the last bit):
    - Capture carry (before update) as c_msb_in.
    - Set cout = c_next.
    - Set overflow = carry ^ c_next.
    - Go to DONE.
- Latency:
  - The acceptance edge is T.
  - RUN occupies edges T+1..T+WIDTH.
  - out_valid is high from edge T+WIDTH onward.
  - Minimum issue interval is WIDTH+2 cycles.
- DONE:
  - out_valid=1; result, cout and overflow are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - Outputs keep their last values after leaving DONE.
  - in_ready=0 in DONE; no overlap with a new operation.
- Backpressure: out_ready low holds DONE indefinitely; outputs do not change.
- Reset mid-operation: rst_n low in RUN or DONE returns to IDLE immediately and clears all outputs. The partial result is discarded.
- Arithmetic: all modulo 2^WIDTH; no saturation.
- Counter width is $clog2(WIDTH); it does not wrap past WIDTH-1 because state leaves RUN.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Add/sub select constants: OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: serial_fa_slice, a combinational 1-bit full adder (inputs a, b, cin; outputs s, cout).
  - Built from two halfadder instances plus an OR gate on the two carries.
  - Instantiated once in serial_addsub.
- Remaining logic is the FSM, counter and shift registers, all in serial_addsub.

Test Plan:
- WIDTH=8, add 0x05+0x03, out_ready=1 -> result 0x08, cout 0, overflow 0. out_valid rises exactly 8 edges after acceptance and lasts 1 cycle.
- Add 0xFF+0x01 -> result 0x00, cout 1, overflow 0. Add 0x7F+0x01 -> result 0x80, cout 0, overflow 1.
- Subtract 0x03-0x05 -> result 0xFE, cout 0, overflow 0. Subtract 0x80-0x01 -> result 0x7F, cout 1, overflow 1.
- Backpressure: add 0x10+0x20 with out_ready=0 for 5 cycles after out_valid rises:
  - result stays 0x30 and out_valid stays 1.
  - in_ready stays 0.
  - The handshake completes on the first out_ready=1 edge.
- Operand change mid-RUN: start 0x11+0x22; hold in_valid=1 with a=0xFF, b=0xFF during RUN -> result 0x33, and no second operation is accepted until back in IDLE.
- Reset mid-RUN: assert rst_n=0 after 3 RUN edges -> in_ready=1, out_valid=0, result=0 immediately. A new operation 0x01+0x01 after release -> result 0x02.
